ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Parametrised instruction-fetch unit for the MIPS datapath.
- Owns the PC register and issues word fetches to instruction memory over a req/ack handshake.
- Buffers fetched instructions, each tagged with its PC and PC+4, in a DEPTH-entry FIFO.
- Presents entries to decode over a valid/ready handshake; a redirect (branch, jump, jr/jalr) flushes the queue and restarts fetch at the target.

Parameters:
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0040_0000, fetch address after reset.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- imem_req_out  out  1  fetch request.
- imem_addr_out  out  ADDR_W  fetch address, word aligned.
- imem_ack_in  in  1  memory accepted request; imem_rdata_in valid this cycle.
- imem_rdata_in  in  DATA_W  fetched instruction.
- ins_valid_out  out  1  head entry valid.
- ins_out  out  DATA_W  head instruction.
- ins_pc_out  out  ADDR_W  PC of head instruction.
- ins_pcn_out  out  ADDR_W  head PC + 4.
- ins_ready_in  in  1  decode consumes head when ins_valid_out is high.
- redirect_in  in  1  flush and refetch.
- redirect_pc_in  in  ADDR_W  new fetch PC.
- count_out  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (reset==0 at a clock edge):
  - fetch_pc = RESET_PC; FIFO empty; state IDLE.
  - imem_req_out=0, imem_addr_out=RESET_PC, ins_valid_out=0, count_out=0.
  - ins_out, ins_pc_out and ins_pcn_out are 0.
  - Reset mid-request abandons the request; any ack is ignored while reset is low.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, result to be kept.
  - DROP: request outstanding, result to be discarded.
- IDLE → WAIT when count + 1 ≤ DEPTH after this cycle's pop, and redirect_in is 0.
  - imem_req_out is registered, asserted the cycle after the decision, with imem_addr_out = fetch_pc.
- Handshake:
  - Once asserted, imem_req_out and imem_addr_out hold stable until the cycle imem_ack_in=1.
  - An ack in the cycle req rises counts.
  - Only one request is ever outstanding.
- WAIT + ack, no redirect:
  - Push {imem_rdata_in, fetch_pc, fetch_pc+4}; fetch_pc += 4.
  - Go to WAIT again (req stays high, new address) if space remains, else IDLE.
- Back-to-back throughput: one instruction per cycle when memory acks every cycle and decode pops every cycle.
- Latency: ack in cycle N → entry visible on ins_*_out in cycle N+1 (no bypass).
- Pop: ins_valid_out & ins_ready_in removes the head at the clock edge. Push and pop in the same cycle leave count unchanged.
- Full: count==DEPTH → no new request; an outstanding request always has a reserved slot, so no overflow.
- Empty: ins_valid_out=0; ins_ready_in is ignored.
- Redirect (redirect_in=1), highest priority:
  - FIFO flushed (count 0 next cycle); any same-cycle pop is ignored.
  - fetch_pc = {redirect_pc_in[ADDR_W-1:2], 2'b00}.
- Redirect by state:
  - In WAIT without ack → DROP.
  - In WAIT with same-cycle ack → data discarded, go to IDLE.
  - In IDLE → IDLE.
- DROP: hold req until ack, discard data, then go to IDLE. A further redirect in DROP only updates fetch_pc.
- Wrap-around: fetch_pc = {ADDR_W{1}} & ~3 plus 4 wraps to 0; pcn wraps identically.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, adds two ports:
  - stat_fetched_out, out, 32: increments per pushed instruction.
  - stat_flushed_out, out, 32: increments by the number of entries discarded per redirect, plus 1 for a dropped in-flight result.
- Both counters reset to 0 and wrap at 2^32.
- When undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Reset release, memory acks every cycle, ins_ready_in=1:
  - First imem_addr_out=0x00400000.
  - ins_pc_out sequence 0x00400000, 0x00400004, 0x00400008.
  - ins_pcn_out = pc+4.
  - Steady 1 instr/cycle.
- Acks every cycle, ins_ready_in=0, DEPTH=4:
  - Exactly 4 acks accepted, then imem_req_out=0 and count_out=4.
  - Raise ready for one cycle: one pop, one new request to 0x00400010.
- Request to 0x00400008 held 3 cycles without ack:
  - Address stable throughout.
  - Redirect_pc_in=0x00400103 asserted cycle 1: state DROP; acked data for 0x00400008 never appears.
  - Next request address 0x00400100.
- Redirect with same-cycle ack and pop, 2 entries queued:
  - count_out=0 next cycle; ins_valid_out=0.
  - Next fetch at redirect target.
  - With FETCH_STATS_EN, stat_flushed_out increases by 3.
- Redirect to 0xFFFFFFFC:
  - Entries carry ins_pc_out 0xFFFFFFFC then 0x00000000.
  - ins_pcn_out 0x00000000 then 0x00000004.
- Reset asserted low while in WAIT:
  - Next cycle imem_req_out=0, count_out=0, imem_addr_out=0x00400000.
  - Ack during reset ignored.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_queue_if
//   Groups the instruction-memory request/ack bus and the decode-side
//   valid/ready bus of the instruction-fetch queue.
//
// Handshakes:
//   imem: imem_req_out/imem_addr_out are held stable from the cycle the
//         request rises until the cycle imem_ack_in=1; that cycle the
//         transfer completes and imem_rdata_in carries the word.
//   ins:  an entry moves to decode at a rising edge where
//         ins_valid_out & ins_ready_in; ins_ready_in is ignored while
//         ins_valid_out is low.
//
// Modports:
//   master - the fetch queue (drives requests and ins_* outputs)
//   slave  - memory/decode side
// ---------------------------------------------------------------------------
interface ifetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_out;
  logic [ADDR_W-1:0] imem_addr_out;
  logic              imem_ack_in;
  logic [DATA_W-1:0] imem_rdata_in;
  logic              ins_valid_out;
  logic [DATA_W-1:0] ins_out;
  logic [ADDR_W-1:0] ins_pc_out;
  logic [ADDR_W-1:0] ins_pcn_out;
  logic              ins_ready_in;
  logic              redirect_in;
  logic [ADDR_W-1:0] redirect_pc_in;

  modport master (
    output imem_req_out, imem_addr_out,
    input  imem_ack_in, imem_rdata_in,
    output ins_valid_out, ins_out, ins_pc_out, ins_pcn_out,
    input  ins_ready_in, redirect_in, redirect_pc_in
  );

  modport slave (
    input  imem_req_out, imem_addr_out,
    output imem_ack_in, imem_rdata_in,
    input  ins_valid_out, ins_out, ins_pc_out, ins_pcn_out,
    output ins_ready_in, redirect_in, redirect_pc_in
  );
endinterface

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Instruction-fetch unit: owns the PC, issues one word fetch at a time to
//   instruction memory and buffers results ({instr, pc, pc+4}) in a
//   DEPTH-entry FIFO presented to decode. A redirect flushes the FIFO and
//   restarts fetch at the (word-aligned) target; a fetch already in flight
//   is completed on the bus and its data discarded.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous, active-low
//   bus        - ifetch_queue_if.master (imem req/ack + decode valid/ready
//                + redirect)
//   count_out  - number of valid FIFO entries
//   state_out  - fetch FSM state (0 IDLE, 1 WAIT, 2 DROP) for observation
//   stat_fetched_out / stat_flushed_out - only with FETCH_STATS_EN defined:
//                pushed-instruction and discarded-instruction counters
//
// Optional feature macro: FETCH_STATS_EN
// ---------------------------------------------------------------------------
module ifetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h0040_0000),
  parameter int                 DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  ifetch_queue_if.master           bus,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic [1:0]               state_out
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]              stat_fetched_out,
  output logic [31:0]              stat_flushed_out
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;

  logic [DATA_W-1:0] mem_ins [DEPTH];
  logic [ADDR_W-1:0] mem_pc  [DEPTH];
  logic [ADDR_W-1:0] mem_pcn [DEPTH];

  logic              ack;
  logic              redirect;
  logic              valid;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count_after_pop;
  logic              room_now;
  logic              room_after_push;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] fetch_pc_inc;
  logic              unused_pc_bits;

  assign ack      = bus.imem_ack_in;
  assign redirect = bus.redirect_in;
  assign valid    = (count_q != '0);

  // A redirect wins over both ends of the FIFO: nothing is pushed or popped
  // in the flush cycle.
  assign pop  = valid & bus.ins_ready_in & ~redirect;
  assign push = (state_q == WAIT) & ack & ~redirect;

  // A new request is only issued when its result is guaranteed a slot, so
  // the FIFO can never overflow.
  assign count_after_pop  = count_q - CW'(pop);
  assign room_now         = (count_after_pop < DEPTH_C);
  assign room_after_push  = ((count_after_pop + CW'(1)) < DEPTH_C);

  assign redirect_target = {bus.redirect_pc_in[ADDR_W-1:2], 2'b00};
  assign fetch_pc_inc    = fetch_pc_q + ADDR_W'(4);
  assign unused_pc_bits  = ^bus.redirect_pc_in[1:0];

  // Next-state / next-PC logic. addr_q is loaded only when a new request
  // starts, so the bus address stays put while a request is outstanding
  // even if fetch_pc is retargeted.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_target;
        end else if (room_now) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_target;
          state_d    = ack ? IDLE : DROP;
        end else if (ack) begin
          fetch_pc_d = fetch_pc_inc;
          if (room_after_push) begin
            addr_d = fetch_pc_inc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_target;
        end
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      if (redirect) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q <= count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset: outputs are gated by valid.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem_ins[wr_ptr_q] <= bus.imem_rdata_in;
      mem_pc[wr_ptr_q]  <= fetch_pc_q;
      mem_pcn[wr_ptr_q] <= fetch_pc_inc;
    end
  end

  assign bus.imem_req_out  = (state_q != IDLE);
  assign bus.imem_addr_out = addr_q;
  assign bus.ins_valid_out = valid;
  assign bus.ins_out       = valid ? mem_ins[rd_ptr_q] : '0;
  assign bus.ins_pc_out    = valid ? mem_pc[rd_ptr_q]  : '0;
  assign bus.ins_pcn_out   = valid ? mem_pcn[rd_ptr_q] : '0;
  assign count_out         = count_q;
  assign state_out         = state_q;

`ifdef FETCH_STATS_EN
  // Flushed count covers the queued entries plus the result of a request
  // that was in flight (WAIT) when the redirect arrived; a redirect in DROP
  // adds nothing for that request since it was already counted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_fetched_out <= '0;
      stat_flushed_out <= '0;
    end else begin
      if (push) stat_fetched_out <= stat_fetched_out + 32'd1;
      if (redirect) begin
        stat_flushed_out <= stat_flushed_out + 32'(count_q)
                            + ((state_q == WAIT) ? 32'd1 : 32'd0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

  logic       clock;
  logic       reset;
  logic [2:0] count_out;
  logic [1:0] state_out;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_out;
  logic [31:0] stat_flushed_out;
  logic [31:0] flushed_before;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int acks     = 0;

  ifetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifetch_queue #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0040_0000), .DEPTH(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .count_out (count_out),
    .state_out (state_out)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched_out (stat_fetched_out),
    .stat_flushed_out (stat_flushed_out)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory returns a word derived from the requested address.
  assign bus.imem_rdata_in = bus.imem_addr_out ^ MAGIC;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish within budget");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.imem_ack_in  = 1'b0;
    bus.ins_ready_in = 1'b0;
    bus.redirect_in  = 1'b0;
    bus.redirect_pc_in = '0;
    step();
    step();
  endtask

  initial begin
    apply_reset();

    // reset state
    check("rst_req",   32'(bus.imem_req_out), 32'd0);
    check("rst_addr",  bus.imem_addr_out, 32'h0040_0000);
    check("rst_valid", 32'(bus.ins_valid_out), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_ins",   bus.ins_out, 32'd0);
    check("rst_pc",    bus.ins_pc_out, 32'd0);
    check("rst_pcn",   bus.ins_pcn_out, 32'd0);

    // streaming: ack every cycle, decode always ready
    reset = 1'b1;
    bus.imem_ack_in  = 1'b1;
    bus.ins_ready_in = 1'b1;
    step();
    check("s_req1",  32'(bus.imem_req_out), 32'd1);
    check("s_addr1", bus.imem_addr_out, 32'h0040_0000);
    step();
    check("s_pc0",   bus.ins_pc_out, 32'h0040_0000);
    check("s_pcn0",  bus.ins_pcn_out, 32'h0040_0004);
    check("s_ins0",  bus.ins_out, 32'h0040_0000 ^ MAGIC);
    check("s_cnt0",  32'(count_out), 32'd1);
    step();
    check("s_pc1",   bus.ins_pc_out, 32'h0040_0004);
    check("s_pcn1",  bus.ins_pcn_out, 32'h0040_0008);
    step();
    check("s_pc2",   bus.ins_pc_out, 32'h0040_0008);
    check("s_cnt2",  32'(count_out), 32'd1);
    check("s_req2",  32'(bus.imem_req_out), 32'd1);

    // fill: ack every cycle, decode stalled
    apply_reset();
    reset = 1'b1;
    bus.imem_ack_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.imem_req_out === 1'b1) acks++;
      step();
    end
    check("f_acks",  32'(acks), 32'd4);
    check("f_req",   32'(bus.imem_req_out), 32'd0);
    check("f_count", 32'(count_out), 32'd4);
    check("f_head",  bus.ins_pc_out, 32'h0040_0000);
    bus.imem_ack_in  = 1'b0;
    bus.ins_ready_in = 1'b1;
    step();
    bus.ins_ready_in = 1'b0;
    check("f_pop_count", 32'(count_out), 32'd3);
    check("f_pop_head",  bus.ins_pc_out, 32'h0040_0004);
    check("f_new_req",   32'(bus.imem_req_out), 32'd1);
    check("f_new_addr",  bus.imem_addr_out, 32'h0040_0010);

    // redirect while a request is held without ack
    apply_reset();
    reset = 1'b1;
    bus.imem_ack_in = 1'b1;
    step();
    step();
    step();
    bus.imem_ack_in = 1'b0;
    check("d_addr0", bus.imem_addr_out, 32'h0040_0008);
    check("d_cnt0",  32'(count_out), 32'd2);
    bus.redirect_in    = 1'b1;
    bus.redirect_pc_in = 32'h0040_0103;
    step();
    bus.redirect_in = 1'b0;
    check("d_state", 32'(state_out), 32'd2);
    check("d_req1",  32'(bus.imem_req_out), 32'd1);
    check("d_addr1", bus.imem_addr_out, 32'h0040_0008);
    check("d_cnt1",  32'(count_out), 32'd0);
    step();
    check("d_addr2", bus.imem_addr_out, 32'h0040_0008);
    bus.imem_ack_in = 1'b1;
    step();
    bus.imem_ack_in = 1'b0;
    check("d_req3",   32'(bus.imem_req_out), 32'd0);
    check("d_valid3", 32'(bus.ins_valid_out), 32'd0);
    check("d_cnt3",   32'(count_out), 32'd0);
    step();
    check("d_req4",  32'(bus.imem_req_out), 32'd1);
    check("d_addr4", bus.imem_addr_out, 32'h0040_0100);

    // redirect with same-cycle ack and pop, two entries queued
    bus.imem_ack_in = 1'b1;
    step();
    step();
    check("r_cnt0", 32'(count_out), 32'd2);
    check("r_pc0",  bus.ins_pc_out, 32'h0040_0100);
`ifdef FETCH_STATS_EN
    flushed_before = stat_flushed_out;
`endif
    bus.ins_ready_in   = 1'b1;
    bus.redirect_in    = 1'b1;
    bus.redirect_pc_in = 32'hFFFF_FFFC;
    step();
    bus.redirect_in  = 1'b0;
    bus.ins_ready_in = 1'b0;
    check("r_cnt1",   32'(count_out), 32'd0);
    check("r_valid1", 32'(bus.ins_valid_out), 32'd0);
    check("r_req1",   32'(bus.imem_req_out), 32'd0);
`ifdef FETCH_STATS_EN
    check("r_flushed", stat_flushed_out - flushed_before, 32'd3);
`endif
    step();
    check("r_req2",  32'(bus.imem_req_out), 32'd1);
    check("r_addr2", bus.imem_addr_out, 32'hFFFF_FFFC);

    // wrap-around of pc and pcn
    step();
    check("w_pc0",   bus.ins_pc_out, 32'hFFFF_FFFC);
    check("w_pcn0",  bus.ins_pcn_out, 32'h0000_0000);
    check("w_ins0",  bus.ins_out, 32'hFFFF_FFFC ^ MAGIC);
    check("w_addr0", bus.imem_addr_out, 32'h0000_0000);
    bus.ins_ready_in = 1'b1;
    step();
    check("w_pc1",  bus.ins_pc_out, 32'h0000_0000);
    check("w_pcn1", bus.ins_pcn_out, 32'h0000_0004);
    check("w_ins1", bus.ins_out, MAGIC);
    check("w_cnt1", 32'(count_out), 32'd1);

    // reset while WAIT, ack held high during reset
    reset = 1'b0;
    step();
    check("x_req0",   32'(bus.imem_req_out), 32'd0);
    check("x_cnt0",   32'(count_out), 32'd0);
    check("x_addr0",  bus.imem_addr_out, 32'h0040_0000);
    check("x_valid0", 32'(bus.ins_valid_out), 32'd0);
    step();
    check("x_cnt1",   32'(count_out), 32'd0);
    check("x_req1",   32'(bus.imem_req_out), 32'd0);
    reset = 1'b1;
    bus.imem_ack_in  = 1'b0;
    bus.ins_ready_in = 1'b0;
    step();
    check("x_req2",   32'(bus.imem_req_out), 32'd1);
    check("x_addr2",  bus.imem_addr_out, 32'h0040_0000);
    check("x_cnt2",   32'(count_out), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
